// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry type.
package cpu_pkg;
  localparam int unsigned WIDTH       = 32;
  localparam logic [WIDTH-1:0] RESET_PC_ADDR = '0;
  localparam int unsigned IFQ_DEPTH   = 2;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [31:0]      instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and memory (slave).
interface ifetch_unit_if #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH
);
  logic             imem_req_valid_o;
  logic             imem_req_ready_i;
  logic [WIDTH-1:0] imem_req_addr_o;
  logic             imem_rsp_valid_i;
  logic [31:0]      imem_rsp_data_i;

  modport master (
    output imem_req_valid_o, imem_req_addr_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i
  );
endinterface

// File: rtl/ifetch_fifo.sv
// Fetch queue of {pc, instr} entries with push/pop/flush and occupancy count.
module ifetch_fifo #(
  parameter int unsigned DEPTH = cpu_pkg::IFQ_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  cpu_pkg::fetch_entry_t        push_data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output cpu_pkg::fetch_entry_t        head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  import cpu_pkg::*;

  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_q, wr_q;
  logic [CW-1:0]      cnt_q;
  logic               pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign pop_ok  = pop_i && valid_o;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= ptr_inc(wr_q);
      if (pop_ok) rd_q <= ptr_inc(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: credit-limited word requests, in-order responses into a
// registered queue, redirect flush with stale-response dropping. Option: IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned DEPTH = cpu_pkg::IFQ_DEPTH
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                redirect_i,
  input  logic [WIDTH-1:0]    redirect_pc_i,
  ifetch_unit_if.master       imem,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [31:0]         instr_o,
  output logic [WIDTH-1:0]    instr_pc_o,
  output logic [WIDTH-1:0]    instr_pc_plus4_o
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,output logic               fetch_misalign_o
`endif
);
  import cpu_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = cpu_pkg::WIDTH;

  logic [WIDTH-1:0] fetch_addr_q, resp_pc_q, redirect_tgt;
  logic [CW-1:0]    out_cnt_q, drop_cnt_q, q_count, out_next;
  logic [CW:0]      credit_sum;
  logic             req_fire, rsp_fire, push, pop, halted;
  fetch_entry_t     push_entry, head_entry;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic halted_q;
  assign redirect_tgt     = redirect_pc_i;
  assign halted           = halted_q;
  assign fetch_misalign_o = halted_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)        halted_q <= 1'b0;
    else if (redirect_i) halted_q <= (redirect_pc_i[1:0] != 2'b00);
  end
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign redirect_tgt  = {redirect_pc_i[WIDTH-1:2], 2'b00};
  assign halted        = 1'b0;
`endif

  // Outstanding plus queued never exceeds DEPTH, so every live response has a free slot.
  assign credit_sum            = {1'b0, out_cnt_q} + {1'b0, q_count};
  assign imem.imem_req_valid_o = rst_n_i && !halted && (credit_sum < (CW+1)'(DEPTH));
  assign imem.imem_req_addr_o  = fetch_addr_q;

  assign req_fire = imem.imem_req_valid_o && imem.imem_req_ready_i;
  assign rsp_fire = imem.imem_rsp_valid_i;
  assign out_next = out_cnt_q + CW'(req_fire) - CW'(rsp_fire);
  assign push     = rsp_fire && !redirect_i && (drop_cnt_q == '0);
  assign pop      = instr_valid_o && instr_ready_i && !redirect_i;

  assign push_entry.pc    = PW'(resp_pc_q);
  assign push_entry.instr = imem.imem_rsp_data_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_addr_q <= RESET_PC_ADDR;
      resp_pc_q    <= RESET_PC_ADDR;
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      out_cnt_q <= out_next;
      if (redirect_i) begin
        // Everything accepted so far, including this cycle's request, is old-path.
        fetch_addr_q <= redirect_tgt;
        resp_pc_q    <= redirect_tgt;
        drop_cnt_q   <= out_next;
      end else begin
        if (req_fire) fetch_addr_q <= fetch_addr_q + WIDTH'(INSTR_BYTES);
        if (push)     resp_pc_q    <= resp_pc_q + WIDTH'(INSTR_BYTES);
        if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - CW'(1);
      end
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (redirect_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .valid_o     (instr_valid_o),
    .head_o      (head_entry),
    .count_o     (q_count)
  );

  assign instr_o          = head_entry.instr;
  assign instr_pc_o       = WIDTH'(head_entry.pc);
  assign instr_pc_plus4_o = instr_pc_o + WIDTH'(INSTR_BYTES);

  a_rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    imem.imem_rsp_valid_i |-> (out_cnt_q != '0));
  a_counters_bounded: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (out_cnt_q <= CW'(DEPTH)) && (drop_cnt_q <= CW'(DEPTH)));
endmodule
